// File: rtl/apb2axi_directory.sv
// apb2axi_directory
//   Tag directory between the APB gateway register file and the AXI request
//   builder. Each committed request gets the lowest EMPTY tag; PENDING entries
//   are handed to the builder round-robin through one registered valid/ready
//   port. Each tag is then tracked through completion and release.
//
//   Slot states (stat_state encoding):
//     0 EMPTY, 1 PENDING, 2 ISSUED, 3 DONE, 4 ERROR
//
//   Ports
//     clk, rst                       clock, synchronous active-high reset
//     alloc_*                        commit request in, gnt/tag out, full out
//     issue_*                        registered issue port to the builder
//     cpl_valid/cpl_tag/cpl_error    completion strobe
//     rel_valid/rel_tag              host release of a completed tag
//     stat_tag/stat_state            combinational state lookup
//     free_cnt/pending_cnt/issued_cnt  per-state occupancy
//     illegal                        one-cycle pulse after an ignored cpl/rel

// Per-slot state machine plus stored request fields.
module apb2axi_directory_slot #(
    parameter int AXI_ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_we,
    input  logic                  alloc_is_write,
    input  logic [AXI_ADDR_W-1:0] alloc_addr,
    input  logic [7:0]            alloc_len,
    input  logic [2:0]            alloc_size,
    input  logic [1:0]            alloc_burst,
    input  logic                  take,
    input  logic                  cpl_ok,
    input  logic                  cpl_error,
    input  logic                  rel_ok,
    output logic [2:0]            state,
    output logic                  is_empty,
    output logic                  is_pending,
    output logic                  is_issued,
    output logic                  is_cpl,
    output logic                  slot_is_write,
    output logic [AXI_ADDR_W-1:0] slot_addr,
    output logic [7:0]            slot_len,
    output logic [2:0]            slot_size,
    output logic [1:0]            slot_burst
);
    localparam logic [2:0] S_EMPTY   = 3'd0;
    localparam logic [2:0] S_PENDING = 3'd1;
    localparam logic [2:0] S_ISSUED  = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    logic [2:0] state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Strobes are qualified by the top against the current state, so at
    // most one of them can be active for a given slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY:         if (alloc_we) state_d = S_PENDING;
            S_PENDING:       if (take)     state_d = S_ISSUED;
            S_ISSUED:        if (cpl_ok)   state_d = cpl_error ? S_ERROR : S_DONE;
            S_DONE, S_ERROR: if (rel_ok)   state_d = S_EMPTY;
            default:                       state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        state      = state_q;
        is_empty   = (state_q == S_EMPTY);
        is_pending = (state_q == S_PENDING);
        is_issued  = (state_q == S_ISSUED);
        is_cpl     = (state_q == S_DONE) || (state_q == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_is_write <= 1'b0;
            slot_addr     <= '0;
            slot_len      <= '0;
            slot_size     <= '0;
            slot_burst    <= '0;
        end else if (alloc_we) begin
            slot_is_write <= alloc_is_write;
            slot_addr     <= alloc_addr;
            slot_len      <= alloc_len;
            slot_size     <= alloc_size;
            slot_burst    <= alloc_burst;
        end
    end
endmodule

module apb2axi_directory #(
    parameter int TAG_NUM    = 16,
    parameter int TAG_W      = $clog2(TAG_NUM),
    parameter int AXI_ADDR_W = 64,
    parameter int CNT_W      = $clog2(TAG_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    input  logic                  alloc_is_write,
    input  logic [AXI_ADDR_W-1:0] alloc_addr,
    input  logic [7:0]            alloc_len,
    input  logic [2:0]            alloc_size,
    input  logic [1:0]            alloc_burst,
    output logic                  alloc_gnt,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic                  full,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic                  issue_is_write,
    output logic [AXI_ADDR_W-1:0] issue_addr,
    output logic [7:0]            issue_len,
    output logic [2:0]            issue_size,
    output logic [1:0]            issue_burst,
    output logic [TAG_W-1:0]      issue_tag,
    input  logic                  cpl_valid,
    input  logic [TAG_W-1:0]      cpl_tag,
    input  logic                  cpl_error,
    input  logic                  rel_valid,
    input  logic [TAG_W-1:0]      rel_tag,
    input  logic [TAG_W-1:0]      stat_tag,
    output logic [2:0]            stat_state,
    output logic [CNT_W-1:0]      free_cnt,
    output logic [CNT_W-1:0]      pending_cnt,
    output logic [CNT_W-1:0]      issued_cnt,
    output logic                  illegal
);
    logic [TAG_NUM-1:0][2:0]            slot_state;
    logic [TAG_NUM-1:0]                 empty_v, pending_v, issued_v, cpl_v;
    logic [TAG_NUM-1:0]                 slot_wr;
    logic [TAG_NUM-1:0][AXI_ADDR_W-1:0] slot_addr;
    logic [TAG_NUM-1:0][7:0]            slot_len;
    logic [TAG_NUM-1:0][2:0]            slot_size;
    logic [TAG_NUM-1:0][1:0]            slot_burst;
    logic [TAG_NUM-1:0]                 slot_take, cpl_hit, rel_hit;

    logic [TAG_W-1:0]      rr_ptr, sel_idx, rr_next;
    logic                  sel_found, issue_load, issue_take;
    logic                  cpl_block, cpl_any, rel_any;
    logic                  sel_wr;
    logic [AXI_ADDR_W-1:0] sel_addr;
    logic [7:0]            sel_len;
    logic [2:0]            sel_size;
    logic [1:0]            sel_burst;
    int                    idx;

    // Allocation: lowest EMPTY slot, gated by the registered occupancy.
    assign full      = (free_cnt == '0);
    assign alloc_gnt = alloc_req & ~full;

    always_comb begin
        alloc_tag = '0;
        for (int i = TAG_NUM - 1; i >= 0; i--)
            if (empty_v[i]) alloc_tag = TAG_W'(i);
    end

    // Round-robin pick over pre-edge PENDING slots, starting at rr_ptr.
    assign issue_load = ~issue_valid | issue_ready;
    assign issue_take = issue_load & sel_found;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < TAG_NUM; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= TAG_NUM) idx = idx - TAG_NUM;
            if (!sel_found && pending_v[TAG_W'(idx)]) begin
                sel_found = 1'b1;
                sel_idx   = TAG_W'(idx);
            end
        end
    end

    assign rr_next = (sel_idx == TAG_W'(TAG_NUM - 1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int i = 0; i < TAG_NUM; i++) begin
            if (sel_idx == TAG_W'(i)) begin
                sel_wr    = slot_wr[i];
                sel_addr  = slot_addr[i];
                sel_len   = slot_len[i];
                sel_size  = slot_size[i];
                sel_burst = slot_burst[i];
            end
        end
    end

    // A completion for the entry still sitting unaccepted in the issue
    // register cannot be real: the builder has not seen it yet.
    assign cpl_block = issue_valid & ~issue_ready & (cpl_tag == issue_tag);

    genvar g;
    generate
        for (g = 0; g < TAG_NUM; g++) begin : g_slot
            assign slot_take[g] = issue_take & (sel_idx == TAG_W'(g));
            assign cpl_hit[g]   = cpl_valid & ~cpl_block & (cpl_tag == TAG_W'(g)) & issued_v[g];
            assign rel_hit[g]   = rel_valid & (rel_tag == TAG_W'(g)) & cpl_v[g];

            apb2axi_directory_slot #(.AXI_ADDR_W(AXI_ADDR_W)) u_slot (
                .clk           (clk),
                .rst           (rst),
                .alloc_we      (alloc_gnt & (alloc_tag == TAG_W'(g))),
                .alloc_is_write(alloc_is_write),
                .alloc_addr    (alloc_addr),
                .alloc_len     (alloc_len),
                .alloc_size    (alloc_size),
                .alloc_burst   (alloc_burst),
                .take          (slot_take[g]),
                .cpl_ok        (cpl_hit[g]),
                .cpl_error     (cpl_error),
                .rel_ok        (rel_hit[g]),
                .state         (slot_state[g]),
                .is_empty      (empty_v[g]),
                .is_pending    (pending_v[g]),
                .is_issued     (issued_v[g]),
                .is_cpl        (cpl_v[g]),
                .slot_is_write (slot_wr[g]),
                .slot_addr     (slot_addr[g]),
                .slot_len      (slot_len[g]),
                .slot_size     (slot_size[g]),
                .slot_burst    (slot_burst[g])
            );
        end
    endgenerate

    assign cpl_any = |cpl_hit;
    assign rel_any = |rel_hit;

    always_comb begin
        stat_state = 3'd0;
        for (int i = 0; i < TAG_NUM; i++)
            if (stat_tag == TAG_W'(i)) stat_state = slot_state[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid    <= 1'b0;
            issue_is_write <= 1'b0;
            issue_addr     <= '0;
            issue_len      <= '0;
            issue_size     <= '0;
            issue_burst    <= '0;
            issue_tag      <= '0;
            rr_ptr         <= '0;
            free_cnt       <= CNT_W'(TAG_NUM);
            pending_cnt    <= '0;
            issued_cnt     <= '0;
            illegal        <= 1'b0;
        end else begin
            if (issue_load) begin
                issue_valid <= sel_found;
                if (sel_found) begin
                    issue_is_write <= sel_wr;
                    issue_addr     <= sel_addr;
                    issue_len      <= sel_len;
                    issue_size     <= sel_size;
                    issue_burst    <= sel_burst;
                    issue_tag      <= sel_idx;
                    rr_ptr         <= rr_next;
                end
            end
            free_cnt    <= free_cnt - CNT_W'(alloc_gnt) + CNT_W'(rel_any);
            pending_cnt <= pending_cnt + CNT_W'(alloc_gnt) - CNT_W'(issue_take);
            issued_cnt  <= issued_cnt + CNT_W'(issue_take) - CNT_W'(cpl_any);
            illegal     <= (cpl_valid & ~cpl_any) | (rel_valid & ~rel_any);
        end
    end
endmodule

// File: tb/tb_apb2axi_directory.sv
module tb_apb2axi_directory;
    localparam int N  = 16;
    localparam int TW = 4;
    localparam int CW = 5;
    localparam int S_EMPTY = 0, S_PENDING = 1, S_ISSUED = 2, S_DONE = 3, S_ERROR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req, alloc_is_write;
    logic [63:0]   alloc_addr;
    logic [7:0]    alloc_len;
    logic [2:0]    alloc_size;
    logic [1:0]    alloc_burst;
    logic          alloc_gnt, full;
    logic [TW-1:0] alloc_tag;
    logic          issue_valid, issue_ready, issue_is_write;
    logic [63:0]   issue_addr;
    logic [7:0]    issue_len;
    logic [2:0]    issue_size;
    logic [1:0]    issue_burst;
    logic [TW-1:0] issue_tag;
    logic          cpl_valid, cpl_error, rel_valid;
    logic [TW-1:0] cpl_tag, rel_tag, stat_tag;
    logic [2:0]    stat_state;
    logic [CW-1:0] free_cnt, pending_cnt, issued_cnt;
    logic          illegal;

    apb2axi_directory dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_is_write(alloc_is_write), .alloc_addr(alloc_addr),
        .alloc_len(alloc_len), .alloc_size(alloc_size), .alloc_burst(alloc_burst),
        .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .full(full),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_write(issue_is_write),
        .issue_addr(issue_addr), .issue_len(issue_len), .issue_size(issue_size),
        .issue_burst(issue_burst), .issue_tag(issue_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_error(cpl_error),
        .rel_valid(rel_valid), .rel_tag(rel_tag),
        .stat_tag(stat_tag), .stat_state(stat_state),
        .free_cnt(free_cnt), .pending_cnt(pending_cnt), .issued_cnt(issued_cnt),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference directory: one state per tag plus the stored request.
    int          st[N];
    logic        f_wr[N];
    logic [63:0] f_addr[N];
    logic [7:0]  f_len[N];
    logic [2:0]  f_size[N];
    logic [1:0]  f_burst[N];
    bit          m_iv, m_ill, m_fresh;
    int          m_itag, m_rr;
    logic        m_iwr;
    logic [63:0] m_iaddr;
    logic [7:0]  m_ilen;
    logic [2:0]  m_isize;
    logic [1:0]  m_iburst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt(input int s);
        int c = 0;
        for (int i = 0; i < N; i++) if (st[i] == s) c++;
        return c;
    endfunction

    // First tag in state s scanning from 'from' and wrapping; -1 if none.
    function automatic int first_of(input int s, input int from);
        for (int k = 0; k < N; k++) if (st[(from + k) % N] == s) return (from + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) st[i] = S_EMPTY;
        m_iv = 0; m_ill = 0; m_fresh = 1; m_itag = 0; m_rr = 0;
        m_iwr = 0; m_iaddr = '0; m_ilen = '0; m_isize = '0; m_iburst = '0;
    endtask

    task automatic check_regs();
        chk("issue_valid", issue_valid, m_iv);
        if (m_iv || m_fresh) begin
            chk("issue_tag", issue_tag, m_itag);
            chk("issue_is_write", issue_is_write, m_iwr);
            chk("issue_addr", issue_addr, m_iaddr);
            chk("issue_len", issue_len, m_ilen);
            chk("issue_size", issue_size, m_isize);
            chk("issue_burst", issue_burst, m_iburst);
        end
        chk("free_cnt", free_cnt, cnt(S_EMPTY));
        chk("pending_cnt", pending_cnt, cnt(S_PENDING));
        chk("issued_cnt", issued_cnt, cnt(S_ISSUED));
        chk("illegal", illegal, m_ill);
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic cycle();
        int  ns[N];
        int  atag, pick;
        bit  gnt, cok, rok;
        #1;
        atag = first_of(S_EMPTY, 0);
        gnt  = alloc_req && (atag >= 0);
        chk("alloc_gnt", alloc_gnt, gnt);
        chk("full", full, atag < 0);
        if (gnt) chk("alloc_tag", alloc_tag, atag);
        chk("stat_state", stat_state, st[stat_tag]);
        ns   = st;
        cok  = cpl_valid && st[cpl_tag] == S_ISSUED && !(m_iv && !issue_ready && cpl_tag == m_itag);
        rok  = rel_valid && (st[rel_tag] == S_DONE || st[rel_tag] == S_ERROR);
        if (cok) ns[cpl_tag] = cpl_error ? S_ERROR : S_DONE;
        if (rok) ns[rel_tag] = S_EMPTY;
        if (gnt) ns[atag] = S_PENDING;
        pick = (!m_iv || issue_ready) ? first_of(S_PENDING, m_rr) : -2;
        if (pick >= 0) ns[pick] = S_ISSUED;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_fresh = 0;
            m_ill   = (cpl_valid && !cok) || (rel_valid && !rok);
            if (pick >= 0) begin
                m_iv = 1; m_itag = pick; m_rr = (pick + 1) % N;
                m_iwr = f_wr[pick]; m_iaddr = f_addr[pick]; m_ilen = f_len[pick];
                m_isize = f_size[pick]; m_iburst = f_burst[pick];
            end else if (pick == -1) m_iv = 0;
            if (gnt) begin
                f_wr[atag] = alloc_is_write; f_addr[atag] = alloc_addr; f_len[atag] = alloc_len;
                f_size[atag] = alloc_size; f_burst[atag] = alloc_burst;
            end
            st = ns;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle();
        alloc_req = 0; cpl_valid = 0; rel_valid = 0; rst = 0;
    endtask

    task automatic rand_req();
        alloc_is_write = 1'($urandom_range(0, 1));
        alloc_addr     = {$urandom, $urandom};
        alloc_len      = 8'($urandom_range(0, 255));
        alloc_size     = 3'($urandom_range(0, 7));
        alloc_burst    = 2'($urandom_range(0, 2));
    endtask

    task automatic do_alloc();
        idle(); rand_req(); alloc_req = 1; cycle(); alloc_req = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); rst = 0;
    endtask

    function automatic logic [TW-1:0] pick_tag(input int s);
        int r = $urandom_range(0, N - 1);
        int t = first_of(s, r);
        if (t < 0 || $urandom_range(0, 4) == 0) return TW'(r);
        return TW'(t);
    endfunction

    initial begin
        rst = 1; idle(); rst = 1; issue_ready = 0; cpl_tag = 0; cpl_error = 0;
        rel_tag = 0; stat_tag = 0; rand_req();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_regs();
        chk("reset_free", free_cnt, N);
        idle();

        // Fill all 16 slots, then one more request is refused.
        issue_ready = 0;
        for (int i = 0; i < N; i++) do_alloc();
        chk("full_after_fill", full, 1);
        alloc_req = 1; cycle(); alloc_req = 0;

        // Three allocs with a ready builder: issue one cycle after each grant.
        do_reset(); issue_ready = 1;
        do_alloc(); chk("first_iv", issue_valid, 0);
        do_alloc(); chk("iss0", issue_tag, 0);
        do_alloc(); chk("iss1", issue_tag, 1);
        cycle();    chk("iss2", issue_tag, 2);
        stat_tag = 0; cycle(); chk("st0_issued", stat_state, S_ISSUED);

        // Stalled builder holds tag 3; a cpl on it is rejected.
        issue_ready = 0;
        do_alloc(); cycle(); chk("hold_tag", issue_tag, 3);
        for (int i = 0; i < 5; i++) begin
            cpl_valid = (i == 2); cpl_tag = 3; stat_tag = 3;
            cycle();
            chk("hold_stable", issue_tag, 3);
            if (i == 2) chk("cpl_held_illegal", illegal, 1);
        end
        cpl_valid = 0; issue_ready = 1; cycle();

        // Error and OK completions, then release; tag 1 is reused first.
        cpl_valid = 1; cpl_tag = 1; cpl_error = 1; stat_tag = 1; cycle();
        cpl_tag = 2; cpl_error = 0; cycle(); chk("st1_error", stat_state, S_ERROR);
        cpl_valid = 0; rel_valid = 1; rel_tag = 1; stat_tag = 2; cycle();
        chk("st2_done", stat_state, S_DONE);
        rel_tag = 2; cycle(); rel_valid = 0;
        rand_req(); alloc_req = 1; #1 chk("realloc_tag1", alloc_tag, 1); cycle(); idle();

        // Full table; release in the same cycle as a request grants next cycle.
        do_reset(); issue_ready = 1;
        for (int i = 0; i < N; i++) do_alloc();
        cycle(); cycle();
        cpl_valid = 1; cpl_tag = 7; cpl_error = 0; cycle(); cpl_valid = 0;
        rand_req(); alloc_req = 1; rel_valid = 1; rel_tag = 7;
        #1 chk("full_rel_gnt", alloc_gnt, 0);
        cycle(); rel_valid = 0;
        #1 chk("next_gnt", alloc_gnt, 1); chk("next_tag", alloc_tag, 7);
        cycle(); idle();

        // Round-robin wrap: rr at 15 with PENDING at 3 and 15.
        do_reset(); issue_ready = 1;
        for (int i = 0; i < N - 1; i++) do_alloc();
        cycle(); chk("rr_pre", issue_tag, 14);
        issue_ready = 0;
        cpl_valid = 1; cpl_tag = 3; cpl_error = 0; cycle(); cpl_valid = 0;
        rel_valid = 1; rel_tag = 3; cycle(); rel_valid = 0;
        do_alloc();
        rand_req(); alloc_req = 1; #1 chk("alloc15", alloc_tag, 15); cycle(); idle();
        issue_ready = 1; cycle(); chk("wrap_15", issue_tag, 15);
        cycle(); chk("wrap_3", issue_tag, 3);
        rand_req(); alloc_req = 1; rst = 1; cycle(); idle();
        chk("rst_free", free_cnt, N); chk("rst_iv", issue_valid, 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rand_req();
            alloc_req   = ($urandom_range(0, 2) != 0);
            issue_ready = ($urandom_range(0, 3) != 0);
            cpl_valid   = 1'($urandom_range(0, 1));
            cpl_tag     = pick_tag(S_ISSUED);
            cpl_error   = ($urandom_range(0, 3) == 0);
            rel_valid   = 1'($urandom_range(0, 1));
            rel_tag     = pick_tag($urandom_range(0, 1) ? S_DONE : S_ERROR);
            stat_tag    = TW'($urandom_range(0, N - 1));
            rst         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb2axi_directory.md
Name: apb2axi_directory

Overview:
- Parametrised tag directory sitting between the APB gateway register file and the AXI request builder.
- Allocates a free tag per committed request and stores the directory entry.
- Issues pending entries to the builder round-robin through a registered valid/ready port, then tracks each tag through completion and release.
- Replaces the flat typedef-only directory with a stateful table: EMPTY -> PENDING -> ISSUED -> DONE/ERROR -> EMPTY.

Parameters:
TAG_NUM, 16, number of directory slots; any value >= 2, not required to be a power of two
TAG_W, $clog2(TAG_NUM), tag index width
AXI_ADDR_W, 64, stored address width
CNT_W, $clog2(TAG_NUM+1), occupancy counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_req  in  1  gateway commit request
alloc_is_write  in  1  1 = write, 0 = read
alloc_addr  in  AXI_ADDR_W  AXI start address
alloc_len  in  8  AXI len (beats-1)
alloc_size  in  3  AXI size
alloc_burst  in  2  AXI burst
alloc_gnt  out  1  request accepted this cycle
alloc_tag  out  TAG_W  tag assigned; valid only when alloc_gnt=1
full  out  1  no EMPTY slot
issue_valid  out  1  issue register holds an entry
issue_ready  in  1  builder accepts
issue_is_write / issue_addr / issue_len / issue_size / issue_burst / issue_tag  out  1/AXI_ADDR_W/8/3/2/TAG_W  issued entry fields
cpl_valid  in  1  completion strobe
cpl_tag  in  TAG_W  completed tag
cpl_error  in  1  1 = SLVERR/DECERR
rel_valid  in  1  host released a completed tag
rel_tag  in  TAG_W  released tag
stat_tag  in  TAG_W  status lookup index
stat_state  out  3  dir_state_e of stat_tag (combinational)
free_cnt / pending_cnt / issued_cnt  out  CNT_W each  slots in EMPTY / PENDING / ISSUED
illegal  out  1  one-cycle pulse on an ignored cpl or rel

Behaviour:
- Reset (sync, rst=1 at posedge):
  - every slot EMPTY; issue_valid=0; issue fields 0.
  - free_cnt=TAG_NUM; pending_cnt=0; issued_cnt=0; illegal=0; rr_ptr=0.
  - In-flight requests are discarded.
- Allocation:
  - full = (free_cnt==0), from registered state.
  - alloc_gnt = alloc_req & ~full, combinational.
  - alloc_tag = lowest-index EMPTY slot.
  - On grant, the slot is written with the request fields and becomes PENDING at the next edge.
  - alloc_req while full: not granted, no state change; the requester holds the request.
- Issue:
  - Single output register.
  - Load condition: (~issue_valid | issue_ready).
  - On load, select the first PENDING slot at or after rr_ptr, modulo TAG_NUM, wrapping.
  - That slot moves to ISSUED in the same edge; issue_valid=1; fields are copied; rr_ptr = selected+1, wrapping to 0 at TAG_NUM.
  - If no PENDING slot exists, issue_valid clears after a handshake.
  - Fields remain stable while issue_valid & ~issue_ready.
  - Minimum latency is 1 cycle from a PENDING write to issue_valid.
  - Back-to-back handshakes issue one entry per cycle.
  - A slot granted in cycle N is eligible for selection at edge N+1, never at edge N.
- Completion:
  - cpl_valid on an ISSUED tag moves it to DONE (cpl_error=0) or ERROR (cpl_error=1).
  - cpl_valid is ignored and illegal pulses when the tag is any of:
    - not ISSUED;
    - equal to issue_tag while issue_valid=1 and the builder has not yet accepted it.
- Release:
  - rel_valid on a DONE or ERROR tag moves it to EMPTY.
  - Any other state: ignored, illegal pulses.
  - A released slot is allocatable from the next cycle. full, and the lowest-EMPTY search, use pre-edge state.
- Simultaneous events:
  - alloc, issue load, cpl and rel in one cycle all apply, because they target slots in different states.
  - cpl and rel on the same tag in one cycle: cpl applies; rel is illegal, since the tag is not yet DONE.
- Counters:
  - Update each edge from the net change: +/-1 per event.
  - No saturation needed; the invariant free+pending+issued+done+error == TAG_NUM always holds.
- stat_state: combinational read of the slot state register.

Test Plan:
- Reset, 16 allocs on consecutive cycles -> tags 0..15, alloc_gnt high all 16 cycles, full=1 after the 16th edge, 17th alloc_req gets alloc_gnt=0.
- Alloc tags 0,1,2 with issue_ready=1 -> issue_tag 0,1,2 on consecutive cycles, first issue_valid one cycle after the grant, stat_state(0)=ISSUED.
- issue_ready=0 for 5 cycles with tag 3 held -> issue fields stable; cpl_tag=3 during the hold -> illegal pulse, state unchanged.
- cpl tag 1 error=1, cpl tag 2 error=0, rel tags 1 and 2 -> ERROR/DONE then EMPTY, free_cnt +2; next alloc returns tag 1.
- Fill all slots; rel tag 7 while alloc_req in the same cycle -> no grant that cycle, grant tag 7 next cycle.
- rr_ptr=15 with PENDING at 3 and 15 -> issues 15 then 3 (wrap); assert rst mid-stream -> all counters and outputs at reset values the next cycle.
